// File: rtl/fp_addsub_seq.sv
// -----------------------------------------------------------------------------
// fp_addsub_seq
// Multi-cycle floating-point adder/subtractor with valid/ready handshakes.
// Round-to-nearest-even, subnormal inputs flushed to zero, underflowing
// results flushed to signed zero.
//
// Ports
//   clk            rising-edge clock
//   rst            asynchronous active-low reset
//   in_valid       operands and sub are valid
//   in_ready       block can accept (IDLE only), decoded from state
//   para1, para2   operands, packed {sign, exponent, mantissa}
//   sub            0: para1 + para2, 1: para1 - para2
//   out_valid      out / under_overflow valid
//   out_ready      downstream accepts the result
//   out            result, registered
//   under_overflow result overflowed to inf or was flushed to zero
// -----------------------------------------------------------------------------
module fp_addsub_seq #(
    parameter  int unsigned EXP_W = 8,
    parameter  int unsigned MAN_W = 23,
    localparam int unsigned W     = 1 + EXP_W + MAN_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] para1,
    input  logic [W-1:0] para2,
    input  logic         sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out,
    output logic         under_overflow
);

    // Datapath: {hidden, mantissa, guard, round, sticky}
    localparam int unsigned DP_W    = MAN_W + 4;
    localparam int unsigned SH_W    = $clog2(DP_W);
    // Exponent carried with headroom for carry-in and negative excursions
    localparam int unsigned EX_W    = ((EXP_W > SH_W) ? EXP_W : SH_W) + 2;
    localparam int unsigned RND_W   = MAN_W + 2;
    localparam int unsigned EXP_MAX = (1 << EXP_W) - 1;
    localparam logic [W-1:0] QNAN   = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ALIGN = 3'd1,
        S_ADD   = 3'd2,
        S_NORM  = 3'd3,
        S_ROUND = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t state_q, state_d;

    // Control decoded from state
    logic accept;

    // Registered datapath
    logic [W-1:0]      a_q, a_d;
    logic [W-1:0]      b_q, b_d;
    logic              sign_q, sign_d;
    logic              eff_sub_q, eff_sub_d;
    logic [EX_W-1:0]   exp_q, exp_d;
    logic [DP_W-1:0]   siga_q, siga_d;
    logic [DP_W-1:0]   sigb_q, sigb_d;
    logic              spec_q, spec_d;
    logic [W-1:0]      spec_val_q, spec_val_d;
    logic [DP_W:0]     sum_q, sum_d;
    logic [DP_W-1:0]   norm_q, norm_d;
    logic              zero_q, zero_d;
    logic [W-1:0]      out_q, out_d;
    logic              uo_q, uo_d;
    logic              out_valid_q, out_valid_d;

    // Alignment-stage combinational signals
    logic              sa, sb, sx;
    logic [EXP_W-1:0]  ea, eb, ex, ey, diff;
    logic [MAN_W-1:0]  ma, mb;
    logic              a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, swap;
    logic [W-2:0]      mag_a, mag_b;
    logic [DP_W-1:0]   sig_a, sig_b, sig_x, sig_y, sig_y_al, sh_mask;
    logic [SH_W-1:0]   sh;
    logic              sticky;
    logic              spec_c;
    logic [W-1:0]      spec_val_c;

    // Normalise / round combinational signals
    logic [SH_W-1:0]   lzc;
    logic              rnd_up;
    logic [RND_W-1:0]  rnd;
    logic              rnd_carry;
    logic [MAN_W-1:0]  man_r;
    logic [EX_W-1:0]   exp_r;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (in_valid) state_d = S_ALIGN;
            S_ALIGN: state_d = S_ADD;
            S_ADD:   state_d = S_NORM;
            S_NORM:  state_d = S_ROUND;
            S_ROUND: state_d = S_DONE;
            S_DONE:  if (out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        in_ready = 1'b0;
        accept   = 1'b0;
        if (state_q == S_IDLE) begin
            in_ready = 1'b1;
            accept   = in_valid;
        end
    end

    // Classification, magnitude swap and sticky right-shift of the smaller operand
    always_comb begin
        sa     = a_q[W-1];
        ea     = a_q[W-2:MAN_W];
        ma     = a_q[MAN_W-1:0];
        sb     = b_q[W-1];
        eb     = b_q[W-2:MAN_W];
        mb     = b_q[MAN_W-1:0];

        a_zero = (ea == '0);
        b_zero = (eb == '0);
        a_inf  = (ea == '1) && (ma == '0);
        b_inf  = (eb == '1) && (mb == '0);
        a_nan  = (ea == '1) && (ma != '0);
        b_nan  = (eb == '1) && (mb != '0);

        // Subnormals count as zero magnitude
        mag_a  = a_zero ? '0 : a_q[W-2:0];
        mag_b  = b_zero ? '0 : b_q[W-2:0];
        swap   = (mag_b > mag_a);

        sig_a  = a_zero ? '0 : {1'b1, ma, 3'b000};
        sig_b  = b_zero ? '0 : {1'b1, mb, 3'b000};

        sx     = swap ? sb : sa;
        ex     = swap ? eb : ea;
        ey     = swap ? ea : eb;
        sig_x  = swap ? sig_b : sig_a;
        sig_y  = swap ? sig_a : sig_b;

        diff   = ex - ey;
        // Saturate so the hidden bit can at worst land in the sticky position
        if (32'(diff) > (DP_W - 1)) begin
            sh = SH_W'(DP_W - 1);
        end else begin
            sh = SH_W'(diff);
        end
        sh_mask  = ~({DP_W{1'b1}} << sh);
        sticky   = |(sig_y & sh_mask);
        sig_y_al = (sig_y >> sh) | DP_W'(sticky);

        // Special-case result, applied in place of the arithmetic one later
        spec_c     = 1'b0;
        spec_val_c = '0;
        if (a_nan || b_nan || (a_inf && b_inf && (sa != sb))) begin
            spec_c     = 1'b1;
            spec_val_c = QNAN;
        end else if (a_inf) begin
            spec_c     = 1'b1;
            spec_val_c = {sa, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (b_inf) begin
            spec_c     = 1'b1;
            spec_val_c = {sb, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (a_zero && b_zero) begin
            // Only -0 + -0 keeps a negative sign
            spec_c     = 1'b1;
            spec_val_c = {sa & sb, {(W-1){1'b0}}};
        end
    end

    // Leading-zero count of the non-carry sum; highest set bit wins
    always_comb begin
        lzc = '0;
        for (int i = 0; i < DP_W; i++) begin
            if (sum_q[i]) lzc = SH_W'(DP_W - 1 - i);
        end
    end

    // Round-to-nearest-even on the normalised significand
    always_comb begin
        rnd_up    = norm_q[2] && (norm_q[1] || norm_q[0] || norm_q[3]);
        rnd       = {1'b0, norm_q[DP_W-1:3]} + RND_W'(rnd_up);
        rnd_carry = rnd[RND_W-1];
        man_r     = rnd_carry ? rnd[MAN_W:1] : rnd[MAN_W-1:0];
        exp_r     = exp_q + EX_W'(rnd_carry);
    end

    // Datapath next-state
    always_comb begin
        a_d         = a_q;
        b_d         = b_q;
        sign_d      = sign_q;
        eff_sub_d   = eff_sub_q;
        exp_d       = exp_q;
        siga_d      = siga_q;
        sigb_d      = sigb_q;
        spec_d      = spec_q;
        spec_val_d  = spec_val_q;
        sum_d       = sum_q;
        norm_d      = norm_q;
        zero_d      = zero_q;
        out_d       = out_q;
        uo_d        = uo_q;
        out_valid_d = out_valid_q;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    a_d = para1;
                    // Subtraction folds into an add of the negated operand
                    b_d = {para2[W-1] ^ sub, para2[W-2:0]};
                end
            end
            S_ALIGN: begin
                sign_d     = sx;
                eff_sub_d  = sa ^ sb;
                exp_d      = EX_W'(ex);
                siga_d     = sig_x;
                sigb_d     = sig_y_al;
                spec_d     = spec_c;
                spec_val_d = spec_val_c;
            end
            S_ADD: begin
                // A has the larger magnitude, so the difference is never negative
                if (eff_sub_q) begin
                    sum_d = {1'b0, siga_q} - {1'b0, sigb_q};
                end else begin
                    sum_d = {1'b0, siga_q} + {1'b0, sigb_q};
                end
            end
            S_NORM: begin
                zero_d = (sum_q == '0);
                if (sum_q[DP_W]) begin
                    norm_d = {sum_q[DP_W:2], sum_q[1] | sum_q[0]};
                    exp_d  = exp_q + EX_W'(1);
                end else begin
                    norm_d = sum_q[DP_W-1:0] << lzc;
                    exp_d  = exp_q - EX_W'(lzc);
                end
            end
            S_ROUND: begin
                out_valid_d = 1'b1;
                uo_d        = 1'b0;
                if (spec_q) begin
                    out_d = spec_val_q;
                end else if (zero_q) begin
                    out_d = '0;
                end else if (!exp_r[EX_W-1] && (exp_r >= EX_W'(EXP_MAX))) begin
                    out_d = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                    uo_d  = 1'b1;
                end else if (exp_r[EX_W-1] || (exp_r == '0)) begin
                    out_d = {sign_q, {(W-1){1'b0}}};
                    uo_d  = 1'b1;
                end else begin
                    out_d = {sign_q, exp_r[EXP_W-1:0], man_r};
                end
            end
            S_DONE: begin
                if (out_ready) out_valid_d = 1'b0;
            end
            default: begin
                out_valid_d = 1'b0;
            end
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_q         <= '0;
            b_q         <= '0;
            sign_q      <= 1'b0;
            eff_sub_q   <= 1'b0;
            exp_q       <= '0;
            siga_q      <= '0;
            sigb_q      <= '0;
            spec_q      <= 1'b0;
            spec_val_q  <= '0;
            sum_q       <= '0;
            norm_q      <= '0;
            zero_q      <= 1'b0;
            out_q       <= '0;
            uo_q        <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            a_q         <= a_d;
            b_q         <= b_d;
            sign_q      <= sign_d;
            eff_sub_q   <= eff_sub_d;
            exp_q       <= exp_d;
            siga_q      <= siga_d;
            sigb_q      <= sigb_d;
            spec_q      <= spec_d;
            spec_val_q  <= spec_val_d;
            sum_q       <= sum_d;
            norm_q      <= norm_d;
            zero_q      <= zero_d;
            out_q       <= out_d;
            uo_q        <= uo_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out            = out_q;
    assign under_overflow = uo_q;
    assign out_valid      = out_valid_q;

endmodule

// File: tb/tb_fp_addsub_seq.sv
// -----------------------------------------------------------------------------
// tb_fp_addsub_seq
// Scoreboard bench for fp_addsub_seq: single-precision instance for the main
// scenarios plus a half-precision instance for the parameter sweep.
// -----------------------------------------------------------------------------
module tb_fp_addsub_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, sub, out_valid, out_ready, under_overflow;
    logic [31:0] para1, para2, out;

    logic        h_in_valid, h_in_ready, h_sub, h_out_valid, h_out_ready, h_uo;
    logic [15:0] h_para1, h_para2, h_out;

    int n_checks = 0;
    int n_fail   = 0;
    int n_xfer   = 0;

    logic [31:0] sb_val[$];
    logic        sb_flag[$];
    string       sb_tag[$];

    always #5 clk = ~clk;

    fp_addsub_seq dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .para1          (para1),
        .para2          (para2),
        .sub            (sub),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out            (out),
        .under_overflow (under_overflow)
    );

    fp_addsub_seq #(.EXP_W(5), .MAN_W(10)) dut_h (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (h_in_valid),
        .in_ready       (h_in_ready),
        .para1          (h_para1),
        .para2          (h_para2),
        .sub            (h_sub),
        .out_valid      (h_out_valid),
        .out_ready      (h_out_ready),
        .out            (h_out),
        .under_overflow (h_uo)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Result monitor: a transfer happens on the next rising edge
    always @(negedge clk) begin : mon
        string       t;
        logic [31:0] v;
        logic        f;
        if (rst && out_valid && out_ready) begin
            n_xfer++;
            if (sb_val.size() == 0) begin
                check_eq("unexpected_out", 64'(out_valid), 64'd0);
            end else begin
                t = sb_tag.pop_front();
                v = sb_val.pop_front();
                f = sb_flag.pop_front();
                check_eq({t, "_val"}, 64'(out), 64'(v));
                check_eq({t, "_flag"}, 64'(under_overflow), 64'(f));
            end
        end
    end

    // Present one operation, wait for acceptance, record the expected result
    task automatic issue(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic s, input logic [31:0] exp_v, input logic exp_f);
        bit got = 1'b0;
        para1    = a;
        para2    = b;
        sub      = s;
        in_valid = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (in_ready) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            check_eq({tag, "_accept"}, 64'(in_ready), 64'd1);
        end else begin
            sb_tag.push_back(tag);
            sb_val.push_back(exp_v);
            sb_flag.push_back(exp_f);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        bit ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk);
            #1;
            if (sb_val.size() == 0 && in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check_eq({tag, "_drain"}, 64'(sb_val.size()), 64'd0);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int  xfer_before;
        bit  seen;
        rst         = 1'b0;
        in_valid    = 1'b0;
        sub         = 1'b0;
        para1       = '0;
        para2       = '0;
        out_ready   = 1'b1;
        h_in_valid  = 1'b0;
        h_sub       = 1'b0;
        h_para1     = '0;
        h_para2     = '0;
        h_out_ready = 1'b1;

        // Reset state
        #12;
        check_eq("rst_out", 64'(out), 64'd0);
        check_eq("rst_out_valid", 64'(out_valid), 64'd0);
        check_eq("rst_flag", 64'(under_overflow), 64'd0);
        check_eq("rst_in_ready", 64'(in_ready), 64'd1);
        check_eq("rst_h_out", 64'(h_out), 64'd0);
        check_eq("rst_h_in_ready", 64'(h_in_ready), 64'd1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Latency: valid appears exactly four edges after the accept edge
        issue("add_basic", 32'h41480000, 32'h40A80000, 1'b0, 32'h418E0000, 1'b0);
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk);
            #1;
            check_eq($sformatf("lat_e%0d", k), 64'(out_valid), 64'd0);
        end
        @(posedge clk);
        #1;
        check_eq("lat_e4", 64'(out_valid), 64'd1);

        issue("sub_basic",  32'h41A20000, 32'h414C0000, 1'b1, 32'h40F00000, 1'b0);
        issue("tie_even",   32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 1'b0);
        issue("tie_odd",    32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, 1'b0);
        issue("cancel",     32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 1'b0);
        issue("underflow",  32'h00800001, 32'h00800000, 1'b1, 32'h00000000, 1'b1);
        issue("overflow",   32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 1'b1);
        issue("inf_m_inf",  32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 1'b0);
        issue("neg_zero",   32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 1'b0);
        issue("nan_in",     32'h7FC00001, 32'h3F800000, 1'b0, 32'h7FC00000, 1'b0);
        issue("inf_fin",    32'hFF800000, 32'h3F800000, 1'b0, 32'hFF800000, 1'b0);
        issue("swap_neg",   32'h3F800000, 32'h40000000, 1'b1, 32'hBF800000, 1'b0);
        issue("denorm_in",  32'h00000001, 32'h3F800000, 1'b0, 32'h3F800000, 1'b0);
        drain("main");

        // Backpressure: result held while out_ready is low, inputs ignored
        out_ready = 1'b0;
        issue("bp", 32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) begin
                seen = 1'b1;
                break;
            end
        end
        check_eq("bp_valid_seen", 64'(seen), 64'd1);
        in_valid = 1'b1;
        para1    = 32'h40400000;
        para2    = 32'h40400000;
        sub      = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check_eq("bp_hold_out", 64'(out), 64'h40000000);
            check_eq("bp_hold_valid", 64'(out_valid), 64'd1);
            check_eq("bp_hold_in_ready", 64'(in_ready), 64'd0);
        end
        xfer_before = n_xfer;
        out_ready   = 1'b1;
        in_valid    = 1'b0;
        @(posedge clk);
        #1;
        check_eq("bp_rel_valid", 64'(out_valid), 64'd0);
        check_eq("bp_rel_in_ready", 64'(in_ready), 64'd1);
        check_eq("bp_rel_out_kept", 64'(out), 64'h40000000);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        check_eq("bp_one_xfer", 64'(n_xfer - xfer_before), 64'd1);

        // Reset while the operation is in the ADD state
        issue("rst_mid", 32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 1'b0);
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        check_eq("rstmid_out", 64'(out), 64'd0);
        check_eq("rstmid_valid", 64'(out_valid), 64'd0);
        check_eq("rstmid_flag", 64'(under_overflow), 64'd0);
        check_eq("rstmid_in_ready", 64'(in_ready), 64'd1);
        sb_val.delete();
        sb_flag.delete();
        sb_tag.delete();
        xfer_before = n_xfer;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst  = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) seen = 1'b1;
        end
        check_eq("rstmid_no_valid", 64'(seen), 64'd0);
        check_eq("rstmid_no_xfer", 64'(n_xfer - xfer_before), 64'd0);

        // Recovery after reset
        issue("post_rst", 32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 1'b0);
        drain("post_rst");

        // Half-precision instance
        h_para1    = 16'h4A40;
        h_para2    = 16'h4540;
        h_sub      = 1'b0;
        h_in_valid = 1'b1;
        seen       = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (h_in_ready) begin
                seen = 1'b1;
                break;
            end
        end
        check_eq("half_accept", 64'(seen), 64'd1);
        @(posedge clk);
        #1;
        h_in_valid = 1'b0;
        seen       = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (h_out_valid) begin
                seen = 1'b1;
                break;
            end
        end
        check_eq("half_valid", 64'(seen), 64'd1);
        check_eq("half_val", 64'(h_out), 64'h4C70);
        check_eq("half_flag", 64'(h_uo), 64'd0);

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
